fir_coef_sequencer: RTL
=======================

// Module: fir_coef_sequencer
// PURPOSE
//   Controller in front of configurable_fir. Holds two coefficient banks (ping-pong) written by a
//   config port, and on commit resets the FIR, streams the new taps into its tap port, then opens
//   the sample path. Gates upstream samples so none reach the FIR while it is unprogrammed/reloading.
// PARAMETERS
//   G_TAPS_LOG2    4   log2 total taps; must equal FIR G_NUM_STAGES_LOG2+G_STAGE_DEPTH_LOG2
//   G_TAP_WIDTH    16  coefficient width
//   G_DATA_WIDTH   16  sample width
//   G_FLUSH_CYC    2   cycles fir_enable is held low on each reload (>=1)
// PORTS
//   clk                in   1             clock
//   reset              in   1             synchronous, active-high
//   cfg_wr_addr        in   G_TAPS_LOG2   shadow-bank tap index
//   cfg_wr_data        in   G_TAP_WIDTH   tap value
//   cfg_wr_en          in   1             write strobe (shadow bank)
//   commit             in   1             1-cycle pulse: swap banks, reload FIR
//   busy               out  1             1 in FLUSH/LOAD or commit pending
//   loaded             out  1             1 in RUN (FIR holds valid taps)
//   fir_enable         out  1             drives FIR enable
//   fir_tap_din        out  G_TAP_WIDTH   tap stream to FIR
//   fir_tap_din_valid  out  1
//   fir_tap_din_ready  in   1
//   s_din/_valid/_ready  in/in/out  G_DATA_WIDTH/1/1  upstream sample stream
//   m_din/_valid/_ready  out/out/in G_DATA_WIDTH/1/1  samples to FIR din port
// BEHAVIOUR
//   Reset: state=IDLE, active bank=0, pending=0; busy=0, loaded=0, fir_enable=0,
//     fir_tap_din_valid=0, s_din_ready=0, m_din_valid=0; bank contents not reset.
//   Banks: active/shadow select bit. cfg_wr_en writes shadow[addr] in any state, incl. LOAD.
//     Active bank read combinationally at load_cnt (no read latency).
//   FSM (shared enum):
//     IDLE : outputs idle. commit -> swap select, flush_cnt=0 -> FLUSH.
//     FLUSH: fir_enable=0; flush_cnt++; at G_FLUSH_CYC-1 -> LOAD, load_cnt=0.
//     LOAD : fir_enable=1; fir_tap_din_valid=1, fir_tap_din=active[load_cnt];
//            on valid&ready: load_cnt++; on last (load_cnt==2**G_TAPS_LOG2-1) -> RUN
//            (or -> FLUSH with swap if pending, clearing pending).
//     RUN  : fir_enable=1, loaded=1; m_din=s_din, m_din_valid=s_din_valid,
//            s_din_ready=m_din_ready (combinational pass-through, zero latency).
//            commit -> swap, FLUSH (sample in flight inside FIR is discarded by its reset).
//   Commit during FLUSH/LOAD: set pending (no swap now); multiple commits collapse to one.
//     Swap happens when pending is serviced, so taps written meanwhile are included.
//   Commit same cycle as cfg_wr_en: write lands in pre-swap shadow (becomes active).
//   Sample path: s_din_ready=0 and m_din_valid=0 in every state but RUN.
//   fir_tap_din stable while valid && !ready. Total reload latency commit->loaded =
//     1 + G_FLUSH_CYC + 2**G_TAPS_LOG2 cycles minimum (ready always high after FIR INIT).
//   load_cnt width G_TAPS_LOG2; wrap never reached (exit on last index).
//   reset mid-LOAD: returns to IDLE, fir_enable=0 (FIR re-inits), loaded=0.
// STRUCTURE
//   fir_ctrl_pkg: seq_state_t {SEQ_IDLE,SEQ_FLUSH,SEQ_LOAD,SEQ_RUN}; tap-count localparams.
//   Sub-module fir_coef_bank: 2-bank regfile, 1 write port (shadow), 1 async read (active),
//     select bit input. Top holds FSM, counters, pending flag, stream gating.
// TESTING (bench instantiates configurable_fir, N=M=4 -> 16 taps)
//   1 Write taps 1..16 to shadow, commit -> fir_enable low 2 cyc, 16 tap handshakes in order
//     1..16, loaded=1 at cycle 19 after commit; then samples pass, s_din_ready follows m_din_ready.
//   2 Before commit: s_din_valid=1 -> s_din_ready=0, m_din_valid=0 throughout IDLE/FLUSH/LOAD.
//   3 Toggle fir_tap_din_ready 1/0 during LOAD -> fir_tap_din held constant while stalled,
//     no tap skipped or repeated (scoreboard 16 values).
//   4 Commit at tap 7 of LOAD with new taps 100..115 written meanwhile -> first load completes
//     16 taps, busy stays 1, second FLUSH+LOAD streams 100..115, then RUN.
//   5 In RUN, commit -> s_din_ready drops next cycle, fir_enable low 2 cyc, reload old shadow.
//   6 Assert reset at tap 5 of LOAD -> all outputs at reset values next cycle; re-commit reloads
//     full 16 taps from bank select after reset (bank 0 swapped to 1).

Source files
------------

// File: rtl/fir_ctrl_pkg.sv
// Shared types and default sizing for the FIR coefficient sequencer.
`default_nettype none

package fir_ctrl_pkg;

    typedef enum logic [1:0] {
        SEQ_IDLE  = 2'd0,
        SEQ_FLUSH = 2'd1,
        SEQ_LOAD  = 2'd2,
        SEQ_RUN   = 2'd3
    } seq_state_t;

    localparam int unsigned DEF_TAPS_LOG2  = 4;
    localparam int unsigned DEF_TAP_WIDTH  = 16;
    localparam int unsigned DEF_DATA_WIDTH = 16;
    localparam int unsigned DEF_FLUSH_CYC  = 2;

    function automatic int unsigned num_taps(input int unsigned taps_log2);
        return 32'd1 << taps_log2;
    endfunction

endpackage

`default_nettype wire

// File: rtl/fir_coef_bank.sv
// Ping-pong coefficient store: writes go to the shadow bank, reads come
// combinationally from the active bank selected by sel.
`default_nettype none

module fir_coef_bank
    import fir_ctrl_pkg::*;
#(
    parameter int unsigned G_TAPS_LOG2 = DEF_TAPS_LOG2,
    parameter int unsigned G_TAP_WIDTH = DEF_TAP_WIDTH
) (
    input  logic                   clk,
    input  logic                   sel,
    input  logic [G_TAPS_LOG2-1:0] wr_addr,
    input  logic [G_TAP_WIDTH-1:0] wr_data,
    input  logic                   wr_en,
    input  logic [G_TAPS_LOG2-1:0] rd_addr,
    output logic [G_TAP_WIDTH-1:0] rd_data
);

    localparam int unsigned NUM_TAPS = num_taps(G_TAPS_LOG2);

    logic [G_TAP_WIDTH-1:0] mem [2][NUM_TAPS];

    // Contents deliberately not reset; the shadow side is always ~sel.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[~sel][wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[sel][rd_addr];

endmodule

`default_nettype wire

// File: rtl/fir_coef_sequencer.sv
// Reload controller for configurable_fir: swaps coefficient banks on commit,
// flushes and re-programs the FIR, and gates the sample stream until it is loaded.
`default_nettype none

module fir_coef_sequencer
    import fir_ctrl_pkg::*;
#(
    parameter int unsigned G_TAPS_LOG2  = DEF_TAPS_LOG2,
    parameter int unsigned G_TAP_WIDTH  = DEF_TAP_WIDTH,
    parameter int unsigned G_DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned G_FLUSH_CYC  = DEF_FLUSH_CYC
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [G_TAPS_LOG2-1:0]  cfg_wr_addr,
    input  logic [G_TAP_WIDTH-1:0]  cfg_wr_data,
    input  logic                    cfg_wr_en,
    input  logic                    commit,
    output logic                    busy,
    output logic                    loaded,
    output logic                    fir_enable,
    output logic [G_TAP_WIDTH-1:0]  fir_tap_din,
    output logic                    fir_tap_din_valid,
    input  logic                    fir_tap_din_ready,
    input  logic [G_DATA_WIDTH-1:0] s_din,
    input  logic                    s_din_valid,
    output logic                    s_din_ready,
    output logic [G_DATA_WIDTH-1:0] m_din,
    output logic                    m_din_valid,
    input  logic                    m_din_ready
);

    localparam int unsigned NUM_TAPS = num_taps(G_TAPS_LOG2);
    localparam int unsigned FLUSH_W  = (G_FLUSH_CYC > 1) ? $clog2(G_FLUSH_CYC) : 1;
    localparam logic [G_TAPS_LOG2-1:0] LOAD_LAST  = G_TAPS_LOG2'(NUM_TAPS - 1);
    localparam logic [FLUSH_W-1:0]     FLUSH_LAST = FLUSH_W'(G_FLUSH_CYC - 1);

    seq_state_t               state, state_nxt;
    logic                     bank_sel, bank_sel_nxt;
    logic                     pending, pending_nxt;
    logic [FLUSH_W-1:0]       flush_cnt, flush_cnt_nxt;
    logic [G_TAPS_LOG2-1:0]   load_cnt, load_cnt_nxt;

    fir_coef_bank #(
        .G_TAPS_LOG2 (G_TAPS_LOG2),
        .G_TAP_WIDTH (G_TAP_WIDTH)
    ) u_bank (
        .clk     (clk),
        .sel     (bank_sel),
        .wr_addr (cfg_wr_addr),
        .wr_data (cfg_wr_data),
        .wr_en   (cfg_wr_en),
        .rd_addr (load_cnt),
        .rd_data (fir_tap_din)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= SEQ_IDLE;
            bank_sel  <= 1'b0;
            pending   <= 1'b0;
            flush_cnt <= '0;
            load_cnt  <= '0;
        end else begin
            state     <= state_nxt;
            bank_sel  <= bank_sel_nxt;
            pending   <= pending_nxt;
            flush_cnt <= flush_cnt_nxt;
            load_cnt  <= load_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt         = state;
        bank_sel_nxt      = bank_sel;
        pending_nxt       = pending;
        flush_cnt_nxt     = flush_cnt;
        load_cnt_nxt      = load_cnt;
        busy              = pending;
        loaded            = 1'b0;
        fir_enable        = 1'b0;
        fir_tap_din_valid = 1'b0;
        s_din_ready       = 1'b0;
        m_din_valid       = 1'b0;
        m_din             = s_din;

        case (state)
            SEQ_IDLE: begin
                if (commit) begin
                    bank_sel_nxt  = ~bank_sel;
                    flush_cnt_nxt = '0;
                    state_nxt     = SEQ_FLUSH;
                end
            end
            SEQ_FLUSH: begin
                busy = 1'b1;
                if (commit) begin
                    pending_nxt = 1'b1;
                end
                if (flush_cnt == FLUSH_LAST) begin
                    load_cnt_nxt = '0;
                    state_nxt    = SEQ_LOAD;
                end else begin
                    flush_cnt_nxt = flush_cnt + FLUSH_W'(1);
                end
            end
            SEQ_LOAD: begin
                busy              = 1'b1;
                fir_enable        = 1'b1;
                fir_tap_din_valid = 1'b1;
                if (commit) begin
                    pending_nxt = 1'b1;
                end
                if (fir_tap_din_ready) begin
                    load_cnt_nxt = load_cnt + G_TAPS_LOG2'(1);
                    if (load_cnt == LOAD_LAST) begin
                        // A commit landing on the final tap is serviced too, not dropped.
                        if (pending || commit) begin
                            bank_sel_nxt  = ~bank_sel;
                            pending_nxt   = 1'b0;
                            flush_cnt_nxt = '0;
                            state_nxt     = SEQ_FLUSH;
                        end else begin
                            state_nxt = SEQ_RUN;
                        end
                    end
                end
            end
            SEQ_RUN: begin
                fir_enable  = 1'b1;
                loaded      = 1'b1;
                m_din_valid = s_din_valid;
                s_din_ready = m_din_ready;
                if (commit) begin
                    bank_sel_nxt  = ~bank_sel;
                    flush_cnt_nxt = '0;
                    state_nxt     = SEQ_FLUSH;
                end
            end
            default: begin
                state_nxt = SEQ_IDLE;
            end
        endcase
    end

endmodule

`default_nettype wire
